// File: rtl/pc_unit_pkg.sv
// Shared encodings and default constants for the fetch-stage program-counter unit.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        CP_SEQ  = 3'b000,
        CP_JR   = 3'b001,
        CP_J    = 3'b010,
        CP_BR   = 3'b011,
        CP_JAL  = 3'b100,
        CP_RET  = 3'b101,
        CP_TRAP = 3'b110,
        CP_ERET = 3'b111
    } cp_type_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/pc_unit_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on an empty stack is ignored. top is the most recently pushed entry.
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [XLEN-1:0]            push_data,
    output logic [XLEN-1:0]            top,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W:0]   count_q, count_d;

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        wp_d    = wp_q;
        count_d = count_q;
        if (push) begin
            wp_d = wp_q + PTR_W'(1);
            if (count_q != FULL) count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && count_q != '0) begin
            wp_d    = wp_q - PTR_W'(1);
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (rstn && push) mem_q[wp_q] <= push_data;
    end

    assign top   = mem_q[wp_q - PTR_W'(1)];
    assign count = count_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: next-PC mux, EPC, return-address checking and
// stall control. State only advances on edges where step is high.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          IMM_W     = 16,
    parameter int          ADDR_W    = 26,
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] TRAP_VEC  = DEF_TRAP_VEC,
    parameter int          RAS_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          step,
    input  logic [2:0]                    cp_type,
    input  logic                          enbranch,
    input  logic [XLEN-1:0]               regs,
    input  logic [IMM_W-1:0]              immd,
    input  logic [ADDR_W-1:0]             addr,
    output logic [XLEN-1:0]               pc,
    output logic [XLEN-1:0]               npc,
    output logic [XLEN-1:0]               link,
    output logic [XLEN-1:0]               epc,
    output logic                          ras_miss,
    output logic                          misalign,
    output logic [$clog2(RAS_DEPTH):0]    ras_count
);
    logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d;
    logic            ras_miss_q, ras_miss_d, misalign_q, misalign_d;
    logic [XLEN-1:0] pc_plus4, reg_target, jmp_target, br_offset, ras_top;
    logic            ras_push, ras_pop, is_ret, is_jr;

    assign pc_plus4   = pc_q + XLEN'(4);
    assign reg_target = {regs[XLEN-1:2], 2'b00};
    assign jmp_target = {pc_q[XLEN-1:ADDR_W+2], addr, 2'b00};
    assign br_offset  = {{(XLEN-IMM_W-2){immd[IMM_W-1]}}, immd, 2'b00};

    assign is_ret   = (cp_type_e'(cp_type) == CP_RET);
    assign is_jr    = (cp_type_e'(cp_type) == CP_JR);
    assign ras_push = step && (cp_type_e'(cp_type) == CP_JAL);
    assign ras_pop  = step && is_ret;

    always_comb begin
        npc = pc_plus4;
        unique case (cp_type_e'(cp_type))
            CP_SEQ:         npc = pc_plus4;
            CP_JR, CP_RET:  npc = reg_target;
            CP_J, CP_JAL:   npc = jmp_target;
            CP_BR:          npc = enbranch ? pc_plus4 + br_offset : pc_plus4;
            CP_TRAP:        npc = TRAP_VEC[XLEN-1:0];
            CP_ERET:        npc = epc_q;
            default:        npc = pc_plus4;
        endcase
    end

    // The RAS only checks ret targets; the ret itself always follows regs.
    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        ras_miss_d = 1'b0;
        misalign_d = 1'b0;
        if (step) begin
            pc_d       = npc;
            misalign_d = (is_jr || is_ret) && (regs[1:0] != 2'b00);
            if (cp_type_e'(cp_type) == CP_TRAP) epc_d = pc_q;
            if (is_ret) ras_miss_d = (ras_count == '0) || (ras_top != reg_target);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q       <= RESET_PC[XLEN-1:0];
            epc_q      <= '0;
            ras_miss_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            ras_miss_q <= ras_miss_d;
            misalign_q <= misalign_d;
        end
    end

    ras_stack #(.DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras (
        .clk       (clk),
        .rstn      (rstn),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .count     (ras_count)
    );

    assign pc       = pc_q;
    assign link     = pc_plus4;
    assign epc      = epc_q;
    assign ras_miss = ras_miss_q;
    assign misalign = misalign_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Registered program-counter unit for the fetch stage.
- Holds the architectural PC and computes the next PC for the cp_type modes: sequential, register jump, absolute jump, conditional branch, jal/ret, trap and eret.
- Adds a circular return-address stack (RAS) for ret-target checking, an EPC register, and stall control.
- Sits between decode/branch resolution and the instruction-memory address port.

Parameters:
- XLEN, 32, PC/register width.
- IMM_W, 16, branch immediate width (sign-extended, word offset).
- ADDR_W, 26, jump-address field width; XLEN >= ADDR_W+4 is required.
- RESET_PC, 32'h0, PC value after reset.
- TRAP_VEC, 32'h0000_0100, trap target.
- RAS_DEPTH, 8, RAS entries (power of two, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- step  in  1  commit the instruction at pc and load npc; 0 = stall.
- cp_type  in  3  000 seq, 001 jr, 010 j, 011 branch, 100 jal, 101 ret, 110 trap, 111 eret.
- enbranch  in  1  branch taken (used only when cp_type=011).
- regs  in  XLEN  register-jump source value (jr/ret).
- immd  in  IMM_W  branch offset in words.
- addr  in  ADDR_W  absolute jump word address.
- pc  out  XLEN  current PC (registered).
- npc  out  XLEN  next PC (combinational from pc and inputs).
- link  out  XLEN  pc+4 (link value for jal).
- epc  out  XLEN  saved exception PC (registered).
- ras_miss  out  1  one-cycle pulse: ret committed with empty RAS or RAS top != regs.
- misalign  out  1  one-cycle pulse: committed jr/ret with regs[1:0] != 0.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.

Behaviour:
- Reset (rstn=0, asynchronous, overrides step):
  - pc=RESET_PC, epc=0, ras_count=0, RAS pointer=0.
  - ras_miss=0, misalign=0.
  - RAS contents are don't-care.
- All state updates on rising clk only when step=1. With step=0, pc, epc and RAS hold, and ras_miss/misalign go to 0 on the next edge.
- npc, all sums modulo 2^XLEN:
  - seq: pc+4.
  - jr: {regs[XLEN-1:2],2'b00}.
  - j and jal: {pc[XLEN-1:ADDR_W+2], addr, 2'b00}.
  - branch: enbranch ? pc+4+(sext(immd)<<2) : pc+4.
  - ret: {regs[XLEN-1:2],2'b00}.
  - trap: TRAP_VEC.
  - eret: epc.
- Latency: npc is combinational; pc takes npc one edge after step=1.
- jal push: RAS[wp] <= pc+4, wp <= wp+1 mod RAS_DEPTH, ras_count <= min(ras_count+1, RAS_DEPTH).
  - When full, the oldest entry is overwritten (wrap) and ras_count stays at RAS_DEPTH.
- ret pop:
  - If ras_count>0: compare RAS[wp-1] with {regs[XLEN-1:2],2'b00}. ras_miss <= (mismatch). wp <= wp-1, ras_count <= ras_count-1.
  - If ras_count=0: ras_miss <= 1, no pointer change.
  - The ret target is always regs; the RAS is a checker/perf source only.
- trap: epc <= pc. No RAS change.
- eret: pc <= epc. epc unchanged.
- misalign <= 1 on a committed jr/ret with regs[1:0] != 0. The low bits are cleared in npc regardless.
- ras_miss and misalign are registered pulses, high for exactly the cycle after the committing edge.
- cp_type=011 with enbranch=0 is sequential.
- enbranch is ignored for all other types.
- Reset asserted mid-stall or mid-stream aborts the pending update. There is no partial RAS write.

Decomposition:
- Shared package:
  - cp_type encodings (CP_SEQ, CP_JR, CP_J, CP_BR, CP_JAL, CP_RET, CP_TRAP, CP_ERET).
  - Default RESET_PC and TRAP_VEC constants.
- One sub-module, ras_stack (parametrised RAS_DEPTH, XLEN).
  - Ports: push, pop, push_data, top, count.
  - Circular, overwrite-on-full, pop-on-empty ignored.
- The npc mux stays in pc_unit.

Test Plan:
- Reset → pc=0, epc=0, ras_count=0. Four seq steps → pc=0x10. step=0 for 3 cycles → pc holds at 0x10.
- pc=0x100, branch, immd=16'hFFFF, enbranch=1 → npc=0x100; enbranch=0 → npc=0x104. pc=0x100, j, addr=0x40 → pc=0x100.
- jal at pc=0x200 → ras_count=1, link=0x204. ret with regs=0x204 → pc=0x204, ras_miss=0, ras_count=0. ret with empty RAS, regs=0x300 → pc=0x300, ras_miss pulse.
- RAS_DEPTH=8: nine jal at pcs 0x0..0x20 → ras_count=8. Eight rets with matching regs → no miss; ninth ret → ras_miss=1.
- trap at pc=0x500 → pc=0x100 (TRAP_VEC), epc=0x500. eret → pc=0x500. jr regs=0x403 → pc=0x400, misalign pulse.
- Assert rstn low asynchronously between edges during a jal with step=1 → pc=RESET_PC immediately, ras_count=0, no push after release.
